// File: rtl/evo_xb_pwm_pkg.sv
// rtl/evo_xb_pwm_pkg.sv - shared constants and types for the PWM crossbar slave
package evo_xb_pwm_pkg;

  // Counter / period / duty width
  localparam int CH_CNT_W = 16;

  // Register word offsets from BASE_ADDR; channel n adds 2*n to the PERIOD/DUTY offsets
  localparam int CTRL_OFS    = 0;
  localparam int STATUS_OFS  = 1;
  localparam int PERIOD0_OFS = 2;
  localparam int DUTY0_OFS   = 3;

  // CTRL and STATUS bit positions
  localparam int CTRL_PRESCALE_BIT = 8;
  localparam int STATUS_WRAP_LSB   = 8;

  typedef struct packed {
    logic [CH_CNT_W-1:0] period;
    logic [CH_CNT_W-1:0] duty;
  } ch_cfg_t;

endpackage

// File: rtl/evo_pwm_ch.sv
// rtl/evo_pwm_ch.sv - one double-buffered PWM channel
module evo_pwm_ch
  import evo_xb_pwm_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                tick,
  input  logic                we_period,
  input  logic                we_duty,
  input  logic [CH_CNT_W-1:0] wdata,
  output ch_cfg_t             shadow_o,
  output logic                level_o,
  output logic                wrap_o
);

  ch_cfg_t             shadow_q, shadow_d;
  ch_cfg_t             active_q, active_d;
  logic [CH_CNT_W-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                wrap;

  // Wrap fires on the tick that finds the counter at the active period
  assign wrap = enable && tick && (cnt_q == active_q.period);

  // CSR writes land only in the shadow copy
  always_comb begin
    shadow_d = shadow_q;
    if (we_period) shadow_d.period = wdata;
    if (we_duty)   shadow_d.duty   = wdata;
  end

  // Counter and active config: idle channels track the shadow, running ones reload on wrap
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (!enable) begin
      cnt_d    = '0;
      active_d = shadow_q;
    end else if (tick) begin
      if (wrap) begin
        cnt_d    = '0;
        active_d = shadow_q;
      end else begin
        cnt_d = cnt_q + CH_CNT_W'(1);
      end
    end
  end

  // Output level lags the counter by one cycle
  assign level_d = enable && (cnt_q < active_q.duty);

  // State registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
    end
  end

  assign shadow_o = shadow_q;
  assign level_o  = level_q;
  assign wrap_o   = wrap;

endmodule

// File: rtl/evo_xb_pwm.sv
// rtl/evo_xb_pwm.sv - multi-channel PWM slave with CSR decode and Port E pin-mux
module evo_xb_pwm
  import evo_xb_pwm_pkg::*;
#(
  parameter int                    CSR_AWIDTH    = 6,
  parameter int                    CSR_DWIDTH    = 32,
  parameter logic [CSR_AWIDTH-1:0] BASE_ADDR     = 6'h10,
  parameter int                    NUM_CH        = 4,
  parameter int                    PORT_E_DWIDTH = 32,
  parameter int                    CH_PIN_LSB    = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en16mhz,
  input  logic [CSR_AWIDTH-1:0]    avs_csr_address,
  input  logic                     avs_csr_read,
  input  logic                     avs_csr_write,
  input  logic [CSR_DWIDTH-1:0]    avs_csr_writedata,
  output logic [CSR_DWIDTH-1:0]    avs_csr_readdata,
  output logic                     avs_csr_readdatavalid,
  output logic                     avs_csr_waitrequest,
  output logic [PORT_E_DWIDTH-1:0] port_e_pmux_dir_o,
  output logic [PORT_E_DWIDTH-1:0] port_e_pmux_out_o,
  output logic [PORT_E_DWIDTH-1:0] port_e_pmux_en_o,
  input  logic [PORT_E_DWIDTH-1:0] port_e_pmux_in_i
);

  localparam int LAST_OFS = 1 + 2 * NUM_CH;

  logic [NUM_CH-1:0]     ctrl_en_q, ctrl_en_d;
  logic                  prescale_q, prescale_d;
  logic [NUM_CH-1:0]     wrap_flag_q, wrap_flag_d;
  logic [NUM_CH-1:0]     wrap_clr;
  logic [CSR_DWIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  logic [CSR_AWIDTH-1:0] ofs;
  int                    ofs_i;
  logic                  hit, wr_hit, rd_hit;
  logic                  tick;
  logic [NUM_CH-1:0]     ch_level;
  logic [NUM_CH-1:0]     ch_wrap;
  ch_cfg_t               ch_cfg [NUM_CH];
  logic                  unused_ok;

  // Address decode; a simultaneous read and write is treated as a write only
  assign ofs    = avs_csr_address - BASE_ADDR;
  assign ofs_i  = int'(ofs);
  assign hit    = (avs_csr_address >= BASE_ADDR) && (ofs_i <= LAST_OFS);
  assign wr_hit = avs_csr_write && hit;
  assign rd_hit = avs_csr_read && !avs_csr_write && hit;

  assign tick = prescale_q ? en16mhz : 1'b1;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic we_period, we_duty;
    assign we_period = wr_hit && (ofs_i == PERIOD0_OFS + 2 * n);
    assign we_duty   = wr_hit && (ofs_i == DUTY0_OFS + 2 * n);

    evo_pwm_ch u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (ctrl_en_q[n]),
      .tick      (tick),
      .we_period (we_period),
      .we_duty   (we_duty),
      .wdata     (avs_csr_writedata[CH_CNT_W-1:0]),
      .shadow_o  (ch_cfg[n]),
      .level_o   (ch_level[n]),
      .wrap_o    (ch_wrap[n])
    );
  end

  // CTRL register update
  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    prescale_d = prescale_q;
    if (wr_hit && (ofs_i == CTRL_OFS)) begin
      ctrl_en_d  = avs_csr_writedata[NUM_CH-1:0];
      prescale_d = avs_csr_writedata[CTRL_PRESCALE_BIT];
    end
  end

  // Sticky wrap flags: write-1-to-clear, a wrap in the same cycle keeps the flag set
  always_comb begin
    wrap_clr = '0;
    if (wr_hit && (ofs_i == STATUS_OFS)) begin
      wrap_clr = avs_csr_writedata[STATUS_WRAP_LSB +: NUM_CH];
    end
    wrap_flag_d = (wrap_flag_q & ~wrap_clr) | ch_wrap;
  end

  // Registered read mux; readdata stays zero unless a hit read was accepted
  always_comb begin
    rdata_d  = '0;
    rvalid_d = 1'b0;
    if (rd_hit) begin
      rvalid_d = 1'b1;
      if (ofs_i == CTRL_OFS) begin
        rdata_d[NUM_CH-1:0]       = ctrl_en_q;
        rdata_d[CTRL_PRESCALE_BIT] = prescale_q;
      end else if (ofs_i == STATUS_OFS) begin
        rdata_d[NUM_CH-1:0]               = ch_level;
        rdata_d[STATUS_WRAP_LSB +: NUM_CH] = wrap_flag_q;
      end else begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (ofs_i == PERIOD0_OFS + 2 * n) rdata_d[CH_CNT_W-1:0] = ch_cfg[n].period;
          if (ofs_i == DUTY0_OFS + 2 * n)   rdata_d[CH_CNT_W-1:0] = ch_cfg[n].duty;
        end
      end
    end
  end

  // Pin-mux: each channel owns and drives one Port E bit while enabled
  always_comb begin
    port_e_pmux_dir_o = '0;
    port_e_pmux_out_o = '0;
    port_e_pmux_en_o  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      port_e_pmux_en_o[CH_PIN_LSB + n]  = ctrl_en_q[n];
      port_e_pmux_dir_o[CH_PIN_LSB + n] = ctrl_en_q[n];
      port_e_pmux_out_o[CH_PIN_LSB + n] = ch_level[n];
    end
  end

  // Top-level state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_en_q   <= '0;
      prescale_q  <= 1'b0;
      wrap_flag_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      ctrl_en_q   <= ctrl_en_d;
      prescale_q  <= prescale_d;
      wrap_flag_q <= wrap_flag_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign avs_csr_readdata      = rdata_q;
  assign avs_csr_readdatavalid = rvalid_q;
  assign avs_csr_waitrequest   = 1'b0;

  // Pad input and upper write-data bits have no function here
  assign unused_ok = ^{port_e_pmux_in_i, avs_csr_writedata[CSR_DWIDTH-1:CH_CNT_W]};

endmodule

// File: tb/tb_evo_xb_pwm.sv
// tb/tb_evo_xb_pwm.sv - self-checking bench for evo_xb_pwm
module tb_evo_xb_pwm;

  localparam int BASE = 16;

  logic        clk;
  logic        reset_n;
  logic        en16mhz;
  logic [5:0]  avs_csr_address;
  logic        avs_csr_read;
  logic        avs_csr_write;
  logic [31:0] avs_csr_writedata;
  logic [31:0] avs_csr_readdata;
  logic        avs_csr_readdatavalid;
  logic        avs_csr_waitrequest;
  logic [31:0] port_e_pmux_dir_o;
  logic [31:0] port_e_pmux_out_o;
  logic [31:0] port_e_pmux_en_o;
  logic [31:0] port_e_pmux_in_i;

  int n_assert = 0;
  int n_fail   = 0;

  evo_xb_pwm dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .en16mhz               (en16mhz),
    .avs_csr_address       (avs_csr_address),
    .avs_csr_read          (avs_csr_read),
    .avs_csr_write         (avs_csr_write),
    .avs_csr_writedata     (avs_csr_writedata),
    .avs_csr_readdata      (avs_csr_readdata),
    .avs_csr_readdatavalid (avs_csr_readdatavalid),
    .avs_csr_waitrequest   (avs_csr_waitrequest),
    .port_e_pmux_dir_o     (port_e_pmux_dir_o),
    .port_e_pmux_out_o     (port_e_pmux_out_o),
    .port_e_pmux_en_o      (port_e_pmux_en_o),
    .port_e_pmux_in_i      (port_e_pmux_in_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] a(input int ofs);
    return 6'(BASE + ofs);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] adr, input logic [31:0] data);
    avs_csr_address   = adr;
    avs_csr_writedata = data;
    avs_csr_write     = 1'b1;
    @(negedge clk);
    avs_csr_write     = 1'b0;
  endtask

  task automatic rd(input logic [5:0] adr, input logic [31:0] exp, input string tag);
    avs_csr_address = adr;
    avs_csr_read    = 1'b1;
    @(negedge clk);
    avs_csr_read    = 1'b0;
    chk({tag, " rvalid"}, 32'(avs_csr_readdatavalid), 32'd1);
    chk({tag, " rdata"}, avs_csr_readdata, exp);
    @(negedge clk);
    chk({tag, " rvalid_drop"}, 32'(avs_csr_readdatavalid), 32'd0);
    chk({tag, " rdata_zero"}, avs_csr_readdata, 32'd0);
  endtask

  task automatic rd_miss(input logic [5:0] adr, input string tag);
    avs_csr_address = adr;
    avs_csr_read    = 1'b1;
    @(negedge clk);
    avs_csr_read    = 1'b0;
    chk({tag, " rvalid"}, 32'(avs_csr_readdatavalid), 32'd0);
    chk({tag, " rdata"}, avs_csr_readdata, 32'd0);
  endtask

  // Program one channel, enable it alone and compare its pin against a tick-level model.
  // The model: each tick advances a position modulo (period+1); the pin shows
  // (position < duty) one cycle later; a duty written at sample chg is adopted at
  // the first wrap strictly after the write lands.
  task automatic run_wave(input int ch, input int p, input int d, input int d2,
                          input int chg, input int pre, input int n);
    int   pos;
    int   act_duty;
    logic lvl_exp, lvl_next, written, tk;
    wr(a(2 + 2 * ch), 32'(p));
    wr(a(3 + 2 * ch), 32'(d));
    en16mhz = 1'b0;
    wr(a(0), (32'(pre) << 8) | (32'd1 << ch));
    pos      = 0;
    act_duty = d;
    lvl_exp  = 1'b0;
    written  = 1'b0;
    for (int s = 0; s < n; s++) begin
      chk($sformatf("wave ch%0d p%0d d%0d s%0d out", ch, p, d, s), port_e_pmux_out_o, 32'(lvl_exp) << ch);
      chk($sformatf("wave ch%0d s%0d en", ch, s), port_e_pmux_en_o, 32'd1 << ch);
      chk($sformatf("wave ch%0d s%0d dir", ch, s), port_e_pmux_dir_o, 32'd1 << ch);
      lvl_next = (pos < act_duty);
      en16mhz  = pre != 0 ? ((s % 4) == 3) : 1'($urandom_range(0, 1));
      tk       = pre != 0 ? en16mhz : 1'b1;
      avs_csr_address   = a(3 + 2 * ch);
      avs_csr_writedata = 32'(d2);
      avs_csr_write     = (s == chg);
      if (tk) begin
        if (pos == p) begin
          pos = 0;
          if (written) act_duty = d2;
        end else begin
          pos++;
        end
      end
      if (s == chg) written = 1'b1;
      lvl_exp = lvl_next;
      @(negedge clk);
    end
    avs_csr_write = 1'b0;
    en16mhz       = 1'b0;
    wr(a(0), 32'd0);
  endtask

  initial begin
    reset_n           = 1'b0;
    en16mhz           = 1'b0;
    avs_csr_address   = '0;
    avs_csr_read      = 1'b0;
    avs_csr_write     = 1'b0;
    avs_csr_writedata = '0;
    port_e_pmux_in_i  = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    chk("rst out", port_e_pmux_out_o, 32'd0);
    chk("rst en", port_e_pmux_en_o, 32'd0);
    chk("rst dir", port_e_pmux_dir_o, 32'd0);
    chk("rst rvalid", 32'(avs_csr_readdatavalid), 32'd0);
    chk("rst rdata", avs_csr_readdata, 32'd0);
    chk("rst waitreq", 32'(avs_csr_waitrequest), 32'd0);
    rd(a(1), 32'd0, "rst status");

    // Basic PWM: period 10, high 3
    run_wave(0, 9, 3, 3, -1, 0, 25);

    // CSR readback, unused bits read zero
    rd(a(2), 32'h0000_0009, "rd period0");
    wr(a(2), 32'hABCD_0009);
    rd(a(2), 32'h0000_0009, "rd period0 upper");
    wr(a(0), 32'hFFFF_FE00);
    rd(a(0), 32'd0, "rd ctrl unused");
    wr(a(9), 32'h0000_1234);
    rd(a(9), 32'h0000_1234, "rd duty3 last");

    // Misses
    rd_miss(a(20), "miss base+20");
    rd_miss(a(10), "miss base+10");
    rd_miss(6'(BASE - 1), "miss base-1");
    wr(a(10), 32'hFFFF_FFFF);
    rd(a(0), 32'd0, "ctrl after miss write");

    // Simultaneous read and write: write wins, no read response
    avs_csr_address   = a(4);
    avs_csr_writedata = 32'h55;
    avs_csr_read      = 1'b1;
    avs_csr_write     = 1'b1;
    @(negedge clk);
    avs_csr_read  = 1'b0;
    avs_csr_write = 1'b0;
    chk("rdwr rvalid", 32'(avs_csr_readdatavalid), 32'd0);
    chk("rdwr rdata", avs_csr_readdata, 32'd0);
    rd(a(4), 32'h55, "rdwr period1");

    // Double buffering: duty 7 written mid-period applies after the wrap
    run_wave(0, 9, 3, 7, 5, 0, 32);

    // Duty edge cases
    run_wave(1, 9, 0, 0, -1, 0, 22);
    run_wave(1, 9, 20, 20, -1, 0, 22);
    run_wave(2, 0, 1, 1, -1, 0, 8);

    // Prescale: tick every 4th clk, high 4 low 4
    run_wave(0, 1, 1, 1, -1, 1, 34);

    // Wrap every cycle on ch2; W1C colliding with a wrap keeps the flag
    wr(a(6), 32'd0);
    wr(a(7), 32'd1);
    wr(a(0), 32'd4);
    repeat (3) @(negedge clk);
    wr(a(1), 32'h0000_0F0F);
    rd(a(1), 32'h0000_0404, "status w1c vs wrap");
    wr(a(0), 32'd0);
    wr(a(1), 32'h0000_0F00);
    rd(a(1), 32'd0, "status w1c clear");

    // Randomised channels/periods/duties/mid-run duty rewrites
    for (int t = 0; t < 8; t++) begin
      int ch, p, d, d2, pre, n, chg;
      ch  = $urandom_range(0, 3);
      p   = $urandom_range(0, 12);
      d   = $urandom_range(0, 15);
      d2  = $urandom_range(0, 15);
      pre = $urandom_range(0, 1);
      n   = (p + 1) * 3 * (pre != 0 ? 4 : 1) + 3;
      chg = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, n - 1)) : -1;
      run_wave(ch, p, d, d2, chg, pre, n);
    end

    // Reset mid-activity
    wr(a(2), 32'd9);
    wr(a(3), 32'd3);
    wr(a(0), 32'h0000_0003);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst out", port_e_pmux_out_o, 32'd0);
    chk("midrst en", port_e_pmux_en_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst dir", port_e_pmux_dir_o, 32'd0);
    chk("midrst rvalid", 32'(avs_csr_readdatavalid), 32'd0);
    rd(a(1), 32'd0, "midrst status");
    rd(a(0), 32'd0, "midrst ctrl");
    rd(a(2), 32'd0, "midrst period0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
